// File: rtl/demultiplex_register_if.sv
// rtl/demultiplex_register_if.sv - write/read-back bundle for the demultiplexing slot register
interface demultiplex_register_if #(
    parameter int Width       = 8,
    parameter int AddressSize = 2
);
    localparam int N = 2 ** AddressSize;

    logic [Width-1:0]       D;
    logic [AddressSize-1:0] S;
    logic                   Auto;
    logic                   Write;
    logic                   Consume;
    logic                   Ready;
    logic [Width*N-1:0]     Q;
    logic [N-1:0]           Valid;
    logic [AddressSize-1:0] Pointer;
    logic                   Full;
    logic                   Done;

    modport master (
        output D, S, Auto, Write, Consume,
        input  Ready, Q, Valid, Pointer, Full, Done
    );

    modport slave (
        input  D, S, Auto, Write, Consume,
        output Ready, Q, Valid, Pointer, Full, Done
    );
endinterface

// File: rtl/demultiplex_register.sv
// rtl/demultiplex_register.sv - distributes input words into 2**AddressSize registered slots
module demultiplex_register #(
    parameter int Width       = 8,
    parameter int AddressSize = 2
) (
    input  logic Clock,
    input  logic Reset,
    demultiplex_register_if.slave bus
);
    localparam int N = 2 ** AddressSize;

    logic [Width*N-1:0]     q_q, q_d;
    logic [N-1:0]           valid_q, valid_d;
    logic [N-1:0]           slot_sel;
    logic [AddressSize-1:0] pointer_q, pointer_d;
    logic [AddressSize-1:0] addr;
    logic                   full_q, full_d;
    logic                   done_q, done_d;
    logic                   ready;
    logic                   accept;

    always_comb begin
        ready  = bus.Auto ? (!full_q || bus.Consume) : 1'b1;
        accept = bus.Write && ready;

        // Consume rewinds the auto pointer before the same-cycle write lands
        if (!bus.Auto)
            addr = bus.S;
        else if (bus.Consume)
            addr = '0;
        else
            addr = pointer_q;

        slot_sel       = '0;
        slot_sel[addr] = accept;

        valid_d   = (bus.Consume ? '0 : valid_q) | slot_sel;
        pointer_d = bus.Consume ? '0 : pointer_q;
        if (accept && bus.Auto)
            pointer_d = addr + 1'b1;

        q_d = q_q;
        for (int i = 0; i < N; i++) begin
            if (slot_sel[i])
                q_d[i*Width +: Width] = bus.D;
        end

        full_d = &valid_d;
        done_d = full_d && !full_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_q       <= '0;
            valid_q   <= '0;
            pointer_q <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            q_q       <= q_d;
            valid_q   <= valid_d;
            pointer_q <= pointer_d;
            full_q    <= full_d;
            done_q    <= done_d;
        end
    end

    assign bus.Ready   = ready;
    assign bus.Q       = q_q;
    assign bus.Valid   = valid_q;
    assign bus.Pointer = pointer_q;
    assign bus.Full    = full_q;
    assign bus.Done    = done_q;
endmodule
